// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master drives the request side and the slave (the arithmetic unit) drives status and results.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic             SUB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;
    logic             CARRY;
    logic             OVF;

    modport master (
        output START, SUB, A, B,
        input  BUSY, DONE, RESULT, CARRY, OVF
    );

    modport slave (
        input  START, SUB, A, B,
        output BUSY, DONE, RESULT, CARRY, OVF
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial A+B / A-B using one full-adder cell and a registered carry, LSB first.
// Latency: START sampled at edge k gives DONE after edge k+WIDTH; START is ignored while BUSY (no queueing).
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    serial_add_sub_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res_sr;
    logic             mode;
    logic             c;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;
    logic             done_q;

    logic             start_acc;
    logic             step;
    logic             last;

    logic             bb;
    logic             s;
    logic             c_nxt;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    start_acc = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: invert B per bit and preload the carry with 1.
    always_comb begin
        bb      = sb[0] ^ mode;
        s       = sa[0] ^ bb ^ c;
        c_nxt   = (sa[0] & bb) | (sa[0] & c) | (bb & c);
        res_cat = {s, res_sr};
        res_nxt = res_cat[WIDTH:1];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sa       <= '0;
            sb       <= '0;
            res_sr   <= '0;
            mode     <= 1'b0;
            c        <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last;
            if (start_acc) begin
                sa     <= bus.A;
                sb     <= bus.B;
                mode   <= bus.SUB;
                c      <= bus.SUB;
                cnt    <= '0;
                res_sr <= '0;
            end else if (step) begin
                sa     <= sa >> 1;
                sb     <= sb >> 1;
                c      <= c_nxt;
                res_sr <= res_nxt;
                cnt    <= cnt + CW'(1);
                // On the MSB step c is the carry into the MSB.
                if (last) begin
                    result_q <= res_nxt;
                    carry_q  <= c_nxt;
                    ovf_q    <= c ^ c_nxt;
                end
            end
        end
    end

    assign bus.BUSY   = (state == RUN);
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;
    assign bus.CARRY  = carry_q;
    assign bus.OVF    = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed-vector bench for serial_add_sub at WIDTH=8 plus a WIDTH=1 instance.
module tb_serial_add_sub;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    serial_add_sub_if #(.WIDTH(8)) bus ();
    serial_add_sub_if #(.WIDTH(1)) bus1 ();

    serial_add_sub #(.WIDTH(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    serial_add_sub #(.WIDTH(1)) dut1 (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the DONE edge with START low.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input bit hold,
                         input logic [7:0] er, input logic ec, input logic eo);
        logic [7:0] r0;
        int         cyc;
        bit         held_ok;
        r0        = bus.RESULT;
        held_ok   = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.SUB   = sub;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.START = 1'b0;
        chk({tag, "_busy"}, 32'(bus.BUSY), 1);
        chk({tag, "_done_lo"}, 32'(bus.DONE), 0);
        cyc = 0;
        while (!bus.DONE && cyc < 20) begin
            if (bus.RESULT !== r0) held_ok = 1'b0;
            if (hold) begin
                bus.A   = ~bus.A;
                bus.B   = bus.B + 8'h33;
                bus.SUB = ~bus.SUB;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.START = 1'b0;
        chk({tag, "_latency"}, 32'(cyc), 8);
        chk({tag, "_held"}, 32'(held_ok), 1);
        chk({tag, "_busy_end"}, 32'(bus.BUSY), 0);
        chk({tag, "_res"}, 32'(bus.RESULT), 32'(er));
        chk({tag, "_carry"}, 32'(bus.CARRY), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.OVF), 32'(eo));
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        int dones;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.DONE) dones++;
        end
        chk({tag, "_no_done"}, 32'(dones), 0);
        chk({tag, "_idle"}, 32'(bus.BUSY), 0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.START  = 1'b0;
        bus.SUB    = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus1.START = 1'b0;
        bus1.SUB   = 1'b0;
        bus1.A     = '0;
        bus1.B     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_done", 32'(bus.DONE), 0);
        chk("rst_res", 32'(bus.RESULT), 0);
        chk("rst_carry", 32'(bus.CARRY), 0);
        chk("rst_ovf", 32'(bus.OVF), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        quiet_cycles("post_first", 2);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("sub_05_03", 8'h05, 8'h03, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0);
        do_op("sub_03_05", 8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
        // Back-to-back: the next START is raised in the DONE cycle.
        do_op("b2b_40_40", 8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("b2b_c0_c0", 8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0);

        do_op("hold_12_34", 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
        quiet_cycles("post_hold", 10);

        // Reset mid-operation, checked before any further clock edge.
        bus.A     = 8'h55;
        bus.B     = 8'h22;
        bus.SUB   = 1'b0;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.BUSY), 0);
        chk("arst_done", 32'(bus.DONE), 0);
        chk("arst_res", 32'(bus.RESULT), 0);
        chk("arst_carry", 32'(bus.CARRY), 0);
        chk("arst_ovf", 32'(bus.OVF), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet_cycles("post_arst", 12);
        do_op("after_rst", 8'h55, 8'h22, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);

        // WIDTH=1: single-step completion, OVF = carry-in ^ carry-out.
        bus1.A     = 1'b1;
        bus1.B     = 1'b1;
        bus1.SUB   = 1'b0;
        bus1.START = 1'b1;
        @(posedge clk);
        #1;
        bus1.START = 1'b0;
        chk("w1_add_busy", 32'(bus1.BUSY), 1);
        @(posedge clk);
        #1;
        chk("w1_add_done", 32'(bus1.DONE), 1);
        chk("w1_add_res", 32'(bus1.RESULT), 0);
        chk("w1_add_carry", 32'(bus1.CARRY), 1);
        chk("w1_add_ovf", 32'(bus1.OVF), 1);
        bus1.A     = 1'b0;
        bus1.B     = 1'b1;
        bus1.SUB   = 1'b1;
        bus1.START = 1'b1;
        @(posedge clk);
        #1;
        bus1.START = 1'b0;
        chk("w1_sub_done_lo", 32'(bus1.DONE), 0);
        @(posedge clk);
        #1;
        chk("w1_sub_done", 32'(bus1.DONE), 1);
        chk("w1_sub_res", 32'(bus1.RESULT), 1);
        chk("w1_sub_carry", 32'(bus1.CARRY), 0);
        chk("w1_sub_ovf", 32'(bus1.OVF), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
